// File: rtl/adpll_pkg.sv
// Shared types and helpers for the ADPLL loop filter.
// Latency: none (package only).
// Backpressure: not applicable.
package adpll_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } lf_state_t;

  localparam int FRAC_W  = 8;
  localparam int CLAMP_W = 32;

  function automatic logic signed [CLAMP_W-1:0] clamp(
    input logic signed [CLAMP_W-1:0] v,
    input logic signed [CLAMP_W-1:0] lo,
    input logic signed [CLAMP_W-1:0] hi
  );
    logic signed [CLAMP_W-1:0] r;
    r = v;
    if (v < lo) r = lo;
    else if (v > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/adpll_lock_detect.sv
// Lock detector: |err| threshold compare feeding a saturating in-lock counter.
// Latency: locked updates on the edge that ends a sample_en cycle.
// Backpressure: none; samples only when sample_en is high.
module adpll_lock_detect #(
  parameter int ERR_W       = 12,
  parameter int LOCK_THRESH = 8,
  parameter int LOCK_COUNT  = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [ERR_W-1:0] err,
  output logic             locked
);

  localparam int CNT_W = $clog2(LOCK_COUNT + 1);

  logic [ERR_W:0] mag;
  logic           in_lock;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             locked_q, locked_d;

  // One extra bit so the magnitude of the most negative error is exact.
  assign mag     = err[ERR_W-1] ? (~{err[ERR_W-1], err} + 1'b1) : {1'b0, err};
  assign in_lock = (mag <= (ERR_W+1)'(LOCK_THRESH));

  always_comb begin
    cnt_d    = cnt_q;
    locked_d = locked_q;
    if (sample_en) begin
      if (!in_lock) cnt_d = '0;
      else if (cnt_q != CNT_W'(LOCK_COUNT)) cnt_d = cnt_q + 1'b1;
      locked_d = (cnt_d == CNT_W'(LOCK_COUNT));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
    end
  end

  assign locked = locked_q;

endmodule

// File: rtl/adpll_loop_filter.sv
// ADPLL PI loop filter: signed phase error in, saturated DCO word out; lock detect under ADPLL_LF_LOCK_DETECT_EN.
// Latency: IDLE->CALC->OUT, ctrl_valid_o one cycle after the CALC cycle; at most one sample per 3 cycles.
// Backpressure: err_ready_o low outside IDLE; OUT holds ctrl_o/sat_o until ctrl_ready_i.
module adpll_loop_filter
  import adpll_pkg::*;
#(
  parameter int              ERR_W       = 12,
  parameter int              CTRL_W      = 16,
  parameter int              KP_SHIFT    = 3,
  parameter int              KI_SHIFT    = 4,
  parameter logic [CTRL_W-1:0] CTRL_INIT = 16'h8000,
  parameter int              LOCK_THRESH = 8,
  parameter int              LOCK_COUNT  = 64
) (
  input  logic              clk5_o,
  input  logic              reset_in,
  input  logic              err_valid_i,
  input  logic [ERR_W-1:0]  err_i,
  output logic              err_ready_o,
  input  logic              freeze_i,
  output logic              ctrl_valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  input  logic              ctrl_ready_i,
  output logic              sat_o,
  output logic              locked_o
);

  localparam int INT_W = CTRL_W + FRAC_W + 1;
  localparam logic signed [CLAMP_W-1:0] INT_MAX  = (32'sd1 <<< (CTRL_W + FRAC_W)) - 32'sd1;
  localparam logic signed [CLAMP_W-1:0] CTRL_MAX = (32'sd1 <<< CTRL_W) - 32'sd1;
  localparam logic signed [CLAMP_W-1:0] INIT_X   = $signed({{(CLAMP_W-CTRL_W){1'b0}}, CTRL_INIT});

  lf_state_t state_q, state_d;

  logic [ERR_W-1:0]  err_q;
  logic              fr_q;
  logic [INT_W-1:0]  int_q, int_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              sat_q, sat_d;

  logic signed [CLAMP_W-1:0] err_x, int_x, cand, sum, ctrl_w;
  logic                      hold_int;

  always_ff @(posedge clk5_o or posedge reset_in) begin
    if (reset_in) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (err_valid_i) state_d = CALC;
      CALC:    state_d = OUT;
      OUT:     if (ctrl_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    err_ready_o  = (state_q == IDLE);
    ctrl_valid_o = (state_q == OUT);
  end

  assign err_x = $signed({{(CLAMP_W-ERR_W){err_q[ERR_W-1]}}, err_q});
  assign int_x = $signed({{(CLAMP_W-INT_W){int_q[INT_W-1]}}, int_q});

  // The clamped integrator candidate feeds the output even when the update is withheld.
  always_comb begin
    cand     = clamp(int_x + (err_x <<< (FRAC_W - KI_SHIFT)), -INT_MAX, INT_MAX);
    sum      = INIT_X + (cand >>> FRAC_W) + (err_x <<< KP_SHIFT);
    ctrl_w   = clamp(sum, 32'sd0, CTRL_MAX);
    ctrl_d   = ctrl_w[CTRL_W-1:0];
    sat_d    = (ctrl_w != sum);
    hold_int = fr_q || ((sum > CTRL_MAX) && (err_x > 0)) || ((sum < 0) && (err_x < 0));
    int_d    = hold_int ? int_q : cand[INT_W-1:0];
  end

  always_ff @(posedge clk5_o or posedge reset_in) begin
    if (reset_in) begin
      err_q  <= '0;
      fr_q   <= 1'b0;
      int_q  <= '0;
      ctrl_q <= CTRL_INIT;
      sat_q  <= 1'b0;
    end else begin
      if (state_q == IDLE && err_valid_i) begin
        err_q <= err_i;
        fr_q  <= freeze_i;
      end
      if (state_q == CALC) begin
        int_q  <= int_d;
        ctrl_q <= ctrl_d;
        sat_q  <= sat_d;
      end
    end
  end

  assign ctrl_o = ctrl_q;
  assign sat_o  = sat_q;

`ifdef ADPLL_LF_LOCK_DETECT_EN
  adpll_lock_detect #(
    .ERR_W      (ERR_W),
    .LOCK_THRESH(LOCK_THRESH),
    .LOCK_COUNT (LOCK_COUNT)
  ) u_lock (
    .clk      (clk5_o),
    .reset    (reset_in),
    .sample_en(state_q == CALC),
    .err      (err_q),
    .locked   (locked_o)
  );
`else
  assign locked_o = 1'b0;
`endif

endmodule

// File: tb/tb_adpll_loop_filter.sv
// Scoreboard bench for adpll_loop_filter: reference PI model predicts each control word at accept time.
// Handles both builds of ADPLL_LF_LOCK_DETECT_EN.
module tb_adpll_loop_filter;

  localparam longint IMAX = (64'sd1 <<< 24) - 1;

  logic        clk5_o = 1'b0;
  logic        reset_in = 1'b1;
  logic        err_valid_i = 1'b0;
  logic [11:0] err_i = '0;
  logic        err_ready_o;
  logic        freeze_i = 1'b0;
  logic        ctrl_valid_o;
  logic [15:0] ctrl_o;
  logic        ctrl_ready_i = 1'b1;
  logic        sat_o;
  logic        locked_o;

  adpll_loop_filter dut (
    .clk5_o      (clk5_o),
    .reset_in    (reset_in),
    .err_valid_i (err_valid_i),
    .err_i       (err_i),
    .err_ready_o (err_ready_o),
    .freeze_i    (freeze_i),
    .ctrl_valid_o(ctrl_valid_o),
    .ctrl_o      (ctrl_o),
    .ctrl_ready_i(ctrl_ready_i),
    .sat_o       (sat_o),
    .locked_o    (locked_o)
  );

  always #5 clk5_o = ~clk5_o;

  typedef struct {
    logic [15:0] ctrl;
    logic        sat;
    logic        lock;
  } exp_t;

  exp_t   sb[$];
  int     total = 0;
  int     bad = 0;
  longint integ = 0;
  int     lcnt = 0;
  logic   exp_lock = 1'b0;

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model(input int e, input bit fr);
    longint cand, sum, c;
    exp_t   x;
    cand = integ + longint'(e) * 16;
    if (cand > IMAX) cand = IMAX;
    else if (cand < -IMAX) cand = -IMAX;
    sum = 32768 + (cand >>> 8) + longint'(e) * 8;
    c = (sum < 0) ? 0 : (sum > 65535) ? 65535 : sum;
    if (!(fr || (sum > 65535 && e > 0) || (sum < 0 && e < 0))) integ = cand;
`ifdef ADPLL_LF_LOCK_DETECT_EN
    if (((e < 0) ? -e : e) <= 8) lcnt = (lcnt < 64) ? lcnt + 1 : 64;
    else lcnt = 0;
    exp_lock = (lcnt == 64);
`else
    exp_lock = 1'b0;
`endif
    x.ctrl = 16'(c);
    x.sat  = (c != sum);
    x.lock = exp_lock;
    sb.push_back(x);
  endtask

  // Called at posedge+1; returns at posedge+1 of the accept edge.
  task automatic send(input int e, input bit fr);
    int n = 0;
    while (!err_ready_o && n < 50) begin
      @(posedge clk5_o); #1;
      n++;
    end
    if (!err_ready_o) check("rdy_timeout", 0, 1);
    err_valid_i = 1'b1;
    err_i       = 12'(e);
    freeze_i    = fr;
    @(posedge clk5_o);
    model(e, fr);
    #1 err_valid_i = 1'b0;
    freeze_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || !err_ready_o) && n < 50) begin
      @(posedge clk5_o); #1;
      n++;
    end
    check("drain_timeout", sb.size(), 0);
  endtask

  always @(negedge clk5_o) begin
    if (!reset_in && ctrl_valid_o && ctrl_ready_i) begin
      if (sb.size() == 0) check("spurious_out", 1, 0);
      else begin
        exp_t x;
        x = sb.pop_front();
        check("sb_ctrl", ctrl_o, x.ctrl);
        check("sb_sat", sat_o, x.sat);
        check("sb_lock", locked_o, x.lock);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] held;

    // Reset values
    repeat (3) @(posedge clk5_o);
    #1;
    check("rst_ctrl", ctrl_o, 16'h8000);
    check("rst_vld", ctrl_valid_o, 0);
    check("rst_sat", sat_o, 0);
    check("rst_lock", locked_o, 0);
    check("rst_rdy", err_ready_o, 1);
    reset_in = 1'b0;
    @(posedge clk5_o); #1;

    // First sample and latency
    send(16, 0);
    check("lat_calc_vld", ctrl_valid_o, 0);
    check("lat_calc_rdy", err_ready_o, 0);
    @(posedge clk5_o); #1;
    check("lat_out_vld", ctrl_valid_o, 1);
    check("first_ctrl", ctrl_o, 16'h8081);
    drain();

    // Freeze holds the integrator
    send(16, 1);
    send(16, 0);
    drain();

    // Positive saturation, then recovery
    for (int i = 0; i < 140; i++) send(2047, 0);
    drain();
    check("pos_sat_ctrl", ctrl_o, 16'hFFFF);
    check("pos_sat_flag", sat_o, 1);
    send(-2048, 0);
    drain();
    check("neg_below_max", (ctrl_o < 16'hFFFF) ? 1 : 0, 1);
    check("neg_sat_flag", sat_o, 0);

    // Backpressure in OUT
    ctrl_ready_i = 1'b0;
    send(100, 0);
    @(posedge clk5_o); #1;
    held = sb[0].ctrl;
    for (int i = 0; i < 5; i++) begin
      check("hold_vld", ctrl_valid_o, 1);
      check("hold_ctrl", ctrl_o, held);
      check("hold_rdy", err_ready_o, 0);
      err_valid_i = (i % 2 == 0);
      err_i       = 12'd5;
      @(posedge clk5_o); #1;
    end
    err_valid_i  = 1'b0;
    ctrl_ready_i = 1'b1;
    drain();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk5_o); #1;
      check("no_extra_vld", ctrl_valid_o, 0);
    end

    // Lock acquisition and loss
    for (int i = 0; i < 64; i++) send((i % 2 == 0) ? 3 : -3, 0);
    drain();
`ifdef ADPLL_LF_LOCK_DETECT_EN
    check("locked_after_64", locked_o, 1);
`else
    check("locked_tied_0", locked_o, 0);
`endif
    send(9, 0);
    drain();
    check("unlock_on_9", locked_o, 0);

    // Reset during CALC
    send(500, 0);
    drain();
    err_valid_i = 1'b1;
    err_i       = 12'd16;
    @(posedge clk5_o); #1;
    err_valid_i = 1'b0;
    reset_in    = 1'b1;
    #1;
    check("midrst_ctrl", ctrl_o, 16'h8000);
    check("midrst_vld", ctrl_valid_o, 0);
    check("midrst_sat", sat_o, 0);
    check("midrst_lock", locked_o, 0);
    check("midrst_rdy", err_ready_o, 1);
    integ = 0;
    lcnt  = 0;
    @(posedge clk5_o); #1;
    reset_in = 1'b0;
    @(posedge clk5_o); #1;
    send(16, 0);
    drain();
    check("post_rst_ctrl", ctrl_o, 16'h8081);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
